decode_pipe: RTL
================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter PC_W, default 32, meaning program-counter width carried with each instruction.
REQ-002 Parameter IMM_W, default 32, meaning width of the extended immediate output; SHALL be >= 16.
REQ-003 Parameter MULDIV_EN, default 1, meaning 1 = mult/multu/div/divu/mfhi/mflo legal, 0 = decoded as illegal.
REQ-004 Parameter CNT_W, default 16, meaning width of the retired-decode counter.
REQ-005 clock  in  1  sole clock, all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  synchronous discard of all buffered entries.
REQ-008 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-009 in_insn / in_pc  in  32 / PC_W  instruction word and its PC.
REQ-010 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-011 out_opcode, out_rs, out_rt, out_rd, out_sa, out_func  out  6,5,5,5,5,6  raw fields [31:26],[25:21],[20:16],[15:11],[10:6],[5:0].
REQ-012 out_imm  out  IMM_W  extended immediate; out_target  out  26  jump target [25:0]; out_pc  out  PC_W.
REQ-013 out_class  out  2  R/I/J/ILLEGAL; out_wr_en  out  1; out_wr_reg  out  5  destination register.
REQ-014 decode_count  out  CNT_W  number of completed output handshakes.

Function
REQ-015 Decode SHALL be combinational on in_insn; results SHALL be captured into a 2-entry skid buffer, giving 1-cycle latency from input handshake to out_valid.
REQ-016 Buffer states EMPTY, ONE, TWO; in_ready = (state != TWO), registered, no combinational path from out_ready.
REQ-017 Transitions: accept only -> +1 entry; output handshake only -> -1 entry; both -> state unchanged, FIFO order preserved.
REQ-018 out_valid = (state != EMPTY); outputs present head entry and SHALL hold stable while out_valid && !out_ready.
REQ-019 Opcode 0x00: class R if func in {20,21,22,23,24,25,26,27,2A,2B,00,02,03,04,06,07,08,09} hex, or {18,19,1A,1B,10,12} when MULDIV_EN=1; otherwise ILLEGAL.
REQ-020 Class J for opcodes 0x02, 0x03; class I for 0x04-0x07, 0x09-0x0F, 0x20, 0x23, 0x24, 0x28, 0x2B, and 0x01 with rt in {0,1}; all else ILLEGAL.
REQ-021 out_imm: zero-extend for 0x0C, 0x0D, 0x0E; {imm,16'b0} extended for LUI 0x0F; sign-extend otherwise.
REQ-022 out_wr_reg/out_wr_en: R ALU/shift/mfhi/mflo/jalr -> rd,1; I ALU and loads -> rt,1; JAL -> 31,1; jr, mult/div, stores, branches, J, ILLEGAL -> 0,0.
REQ-023 Destination register 0 SHALL force out_wr_en = 0.
REQ-024 flush SHALL set state EMPTY next cycle, dropping any simultaneous accept; decode_count not incremented by a same-cycle output handshake.
REQ-025 decode_count increments by 1 per output handshake, wraps from 2^CNT_W-1 to 0.
REQ-026 ILLEGAL instructions SHALL pass through the buffer like any other; no stall.

Reset
REQ-027 reset_n low SHALL immediately set state EMPTY, out_valid 0, in_ready 0, decode_count 0, all payload outputs 0.
REQ-028 in_ready SHALL rise the first clock edge after reset_n deassertion; reset mid-transfer discards all entries.

Structure
REQ-029 Package decode_pkg SHALL hold opcode and func constants, class encoding (R=0, I=1, J=2, ILLEGAL=3) and the decoded-entry record type.
REQ-030 One sub-module insn_decoder SHALL contain the combinational field/class/immediate/writeback logic; decode_pipe holds buffer, handshake, counter.

Verification
REQ-031 add $3,$1,$2 (0x00221820), out_ready=1 -> next cycle class R, rd 3, wr_en 1, wr_reg 3, decode_count 1.
REQ-032 addiu $2,$0,-1 (0x2402FFFF) -> imm 0xFFFFFFFF, wr_reg 2; ori (0x3402FFFF) -> imm 0x0000FFFF; lui (0x3C021234) -> imm 0x12340000.
REQ-033 out_ready=0 while 3 inputs offered -> 2 accepted, in_ready 0, third held; release -> all 3 emerge in order.
REQ-034 MULDIV_EN=0, mult (0x00220018) -> class ILLEGAL, wr_en 0; jal (0x0C000010) -> class J, wr_reg 31, target 0x10.
REQ-035 State TWO, flush asserted with in_valid=1 -> next cycle out_valid 0, in_ready 1, count unchanged; reset_n pulse mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants and record types for the decode stage.
// Imported by insn_decoder and decode_pipe.
package decode_pkg;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_J   = 2'd2,
        CLS_ILL = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] sa;
        logic [5:0] func;
        cls_e       cls;
        logic       wr_en;
        logic [4:0] wr_reg;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/insn_decoder.sv
// Combinational field split, class, immediate and writeback decode.
// Pure function of the instruction word.
module insn_decoder
    import decode_pkg::*;
#(
    parameter int IMM_W     = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic [31:0]      insn,
    output logic [DEC_W-1:0] dec,
    output logic [IMM_W-1:0] imm
);

    logic [5:0]       op;
    logic [5:0]       fn;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [IMM_W-1:0] sext;
    cls_e             cls;
    logic             wr;
    logic [4:0]       dst;
    logic             wr_en;
    dec_t             d;

    assign op   = insn[31:26];
    assign rt   = insn[20:16];
    assign rd   = insn[15:11];
    assign fn   = insn[5:0];
    assign sext = IMM_W'($signed(insn[15:0]));

    always_comb begin
        cls = CLS_ILL;
        wr  = 1'b0;
        dst = 5'd0;
        unique case (op)
            OP_SPECIAL: begin
                unique case (fn)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_JALR, F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        cls = CLS_R;
                        wr  = 1'b1;
                        dst = rd;
                    end
                    F_JR: cls = CLS_R;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        if (MULDIV_EN != 0) cls = CLS_R;
                    end
                    F_MFHI, F_MFLO: begin
                        if (MULDIV_EN != 0) begin
                            cls = CLS_R;
                            wr  = 1'b1;
                            dst = rd;
                        end
                    end
                    default: ;
                endcase
            end
            OP_J: cls = CLS_J;
            OP_JAL: begin
                cls = CLS_J;
                wr  = 1'b1;
                dst = 5'd31;
            end
            OP_REGIMM: begin
                if (rt[4:1] == 4'd0) cls = CLS_I;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_SB, OP_SW:
                cls = CLS_I;
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_LB, OP_LW, OP_LBU: begin
                cls = CLS_I;
                wr  = 1'b1;
                dst = rt;
            end
            default: ;
        endcase
    end

    // LUI is the sign-extended immediate moved up by 16
    always_comb begin
        unique case (op)
            OP_ANDI, OP_ORI, OP_XORI: imm = IMM_W'(insn[15:0]);
            OP_LUI:                   imm = sext << 16;
            default:                  imm = sext;
        endcase
    end

    assign wr_en = wr && (dst != 5'd0);

    always_comb begin
        d.opcode = op;
        d.rs     = insn[25:21];
        d.rt     = rt;
        d.rd     = rd;
        d.sa     = insn[10:6];
        d.func   = fn;
        d.cls    = cls;
        d.wr_en  = wr_en;
        d.wr_reg = wr_en ? dst : 5'd0;
    end

    assign dec = d;

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: combinational decode into a 2-entry skid buffer
// with registered in_ready and a retired-decode counter.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int IMM_W     = 32,
    parameter int MULDIV_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_sa,
    output logic [5:0]       out_func,
    output logic [IMM_W-1:0] out_imm,
    output logic [25:0]      out_target,
    output logic [PC_W-1:0]  out_pc,
    output logic [1:0]       out_class,
    output logic             out_wr_en,
    output logic [4:0]       out_wr_reg,
    output logic [CNT_W-1:0] decode_count
);

    logic [DEC_W-1:0] dec_vec;
    logic [IMM_W-1:0] dec_imm;

    insn_decoder #(
        .IMM_W     (IMM_W),
        .MULDIV_EN (MULDIV_EN)
    ) u_dec (
        .insn (in_insn),
        .dec  (dec_vec),
        .imm  (dec_imm)
    );

    buf_state_e       state, state_nx;
    logic             rdy;
    logic             push, pop;
    dec_t             h_dec, s_dec;
    logic [IMM_W-1:0] h_imm, s_imm;
    logic [PC_W-1:0]  h_pc, s_pc;

    assign push = in_valid && rdy && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            rdy   <= 1'b0;
        end else begin
            state <= state_nx;
            rdy   <= (state_nx != TWO);
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (push) state_nx = ONE;
                ONE: begin
                    if (push && !pop)      state_nx = TWO;
                    else if (!push && pop) state_nx = EMPTY;
                end
                TWO:     if (pop) state_nx = ONE;
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = rdy;
    end

    // Head refills from the skid slot, or directly from decode when
    // the buffer is empty or draining one-for-one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_dec <= '0;
            h_imm <= '0;
            h_pc  <= '0;
            s_dec <= '0;
            s_imm <= '0;
            s_pc  <= '0;
        end else begin
            if (push && (state == EMPTY || (state == ONE && pop))) begin
                h_dec <= dec_t'(dec_vec);
                h_imm <= dec_imm;
                h_pc  <= in_pc;
            end else if (pop && state == TWO) begin
                h_dec <= s_dec;
                h_imm <= s_imm;
                h_pc  <= s_pc;
            end
            if (push && state == ONE && !pop) begin
                s_dec <= dec_t'(dec_vec);
                s_imm <= dec_imm;
                s_pc  <= in_pc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) decode_count <= '0;
        else if (pop) decode_count <= decode_count + 1'b1;
    end

    assign out_opcode = h_dec.opcode;
    assign out_rs     = h_dec.rs;
    assign out_rt     = h_dec.rt;
    assign out_rd     = h_dec.rd;
    assign out_sa     = h_dec.sa;
    assign out_func   = h_dec.func;
    assign out_target = {h_dec.rs, h_dec.rt, h_dec.rd, h_dec.sa, h_dec.func};
    assign out_class  = h_dec.cls;
    assign out_wr_en  = h_dec.wr_en;
    assign out_wr_reg = h_dec.wr_reg;
    assign out_imm    = h_imm;
    assign out_pc     = h_pc;

endmodule
